song_player: RTL

Sequencer that reads the song ROM and plays it out. It steps the ROM address, times each entry's duration, and drives a registered note code to the tone generator. It also inserts a short articulation gap at the end of each note, so repeated notes stay distinct. It sits between the user controls (song select, start/pause/stop) and the buzzer/tone block.

---
 rtl/song_pkg.sv | 25 ++
 rtl/song_player_tick_gen.sv | 48 ++++
 rtl/song_player.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/song_pkg.sv
// song_pkg
// Shared widths, constants and the sequencer state type for the song player.
// Anything that talks to the song ROM or the tone generator imports this so
// the address/note/duration widths only live in one place.

package song_pkg;

  localparam int ADDR_W = 5;
  localparam int NOTE_W = 4;
  localparam int DUR_W  = 16;
  localparam int SONG_W = 4;

  // Highest ROM address; a song never wraps past this entry.
  localparam logic [ADDR_W-1:0] LAST_ADDR = 5'd31;

  // Note code that the tone generator treats as silence.
  localparam logic [NOTE_W-1:0] NOTE_REST = 4'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    PLAY  = 2'd2
  } state_t;

endpackage

// File: rtl/song_player_tick_gen.sv
// tick_gen
// Duration-unit prescaler. Counts TICK_DIV clock cycles per tick while
// enabled, holding its count while disabled so a paused note resumes exactly
// where it stopped.
//
// Ports:
//   clk     system clock
//   rst     synchronous, active-high reset (count cleared to 0)
//   clear   reload the count with TICK_DIV-1 (start of a new note)
//   enable  count this cycle; low holds the count
//   tick    one-cycle pulse on the cycle the count reaches 0 while enabled

module tick_gen #(
  parameter int TICK_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int PRE_W = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] RELOAD = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] count;

  // The tick fires in the last cycle of each unit, so after a clear the
  // first tick arrives exactly TICK_DIV enabled cycles later.
  assign tick = enable && (count == '0);

  // Reload has priority over counting so the FETCH cycle always leaves the
  // prescaler primed for the first PLAY cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= RELOAD;
    end else if (enable) begin
      if (count == '0) begin
        count <= RELOAD;
      end else begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/song_player.sv
// song_player
// Song sequencer: walks the song ROM one entry at a time, holds each note for
// its duration (in TICK_DIV-cycle units) and mutes the last GAP_UNITS units of
// every note so back-to-back repeats of the same pitch stay audibly separate.
//
// Ports:
//   clk           system clock
//   rst           synchronous, active-high reset
//   start         begin playback from address 0 (only honoured in IDLE)
//   pause         level; freezes note timing and mutes output while high
//   stop          abort playback and return to IDLE (highest priority)
//   song_sel      song number, latched into rom_song on an accepted start
//   rom_address   ROM entry address
//   rom_song      latched song number to the ROM
//   rom_note      note code from the ROM (combinational)
//   rom_duration  entry duration in units from the ROM; 0 marks end of song
//   note_out      registered note code to the tone generator, 0 = silence
//   playing       high in FETCH and PLAY, including while paused
//   done          one-cycle pulse when a song ends by itself

module song_player
  import song_pkg::*;
#(
  parameter int TICK_DIV  = 100000,
  parameter int GAP_UNITS = 50
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pause,
  input  logic              stop,
  input  logic [SONG_W-1:0] song_sel,
  output logic [ADDR_W-1:0] rom_address,
  output logic [SONG_W-1:0] rom_song,
  input  logic [NOTE_W-1:0] rom_note,
  input  logic [DUR_W-1:0]  rom_duration,
  output logic [NOTE_W-1:0] note_out,
  output logic              playing,
  output logic              done
);

  localparam logic [DUR_W-1:0] GAP = DUR_W'(GAP_UNITS);

  state_t              state;
  logic [NOTE_W-1:0]   note_reg;
  logic [DUR_W-1:0]    remaining;
  logic [DUR_W-1:0]    remaining_dec;
  logic                tick;
  logic                pre_clear;
  logic                pre_enable;

  // The prescaler is primed during FETCH and only runs in unpaused PLAY.
  assign pre_clear     = (state == FETCH);
  assign pre_enable    = (state == PLAY) && !pause;
  assign remaining_dec = remaining - 1'b1;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .clear  (pre_clear),
    .enable (pre_enable),
    .tick   (tick)
  );

  // Sequencer. note_out is registered, so it is always computed from the
  // value remaining will hold in the next cycle; that keeps the audible part
  // of a note aligned with remaining > GAP_UNITS, not one cycle behind it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rom_address <= '0;
      rom_song    <= '0;
      note_out    <= NOTE_REST;
      note_reg    <= NOTE_REST;
      remaining   <= '0;
      playing     <= 1'b0;
      done        <= 1'b0;
    end else if (stop) begin
      state       <= IDLE;
      rom_address <= '0;
      note_out    <= NOTE_REST;
      remaining   <= '0;
      playing     <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          note_out    <= NOTE_REST;
          rom_address <= '0;
          if (start) begin
            rom_song <= song_sel;
            playing  <= 1'b1;
            state    <= FETCH;
          end
        end

        FETCH: begin
          note_reg  <= rom_note;
          remaining <= rom_duration;
          if (rom_duration == '0) begin
            state       <= IDLE;
            rom_address <= '0;
            note_out    <= NOTE_REST;
            playing     <= 1'b0;
            done        <= 1'b1;
          end else begin
            state    <= PLAY;
            note_out <= (!pause && (rom_duration > GAP)) ? rom_note : NOTE_REST;
          end
        end

        PLAY: begin
          if (tick) begin
            if (remaining == DUR_W'(1)) begin
              remaining <= '0;
              note_out  <= NOTE_REST;
              if (rom_address == LAST_ADDR) begin
                state       <= IDLE;
                rom_address <= '0;
                playing     <= 1'b0;
                done        <= 1'b1;
              end else begin
                rom_address <= rom_address + 1'b1;
                state       <= FETCH;
              end
            end else begin
              remaining <= remaining_dec;
              note_out  <= (remaining_dec > GAP) ? note_reg : NOTE_REST;
            end
          end else if (pause) begin
            note_out <= NOTE_REST;
          end else begin
            note_out <= (remaining > GAP) ? note_reg : NOTE_REST;
          end
        end

        default: begin
          state       <= IDLE;
          rom_address <= '0;
          note_out    <= NOTE_REST;
          playing     <= 1'b0;
        end
      endcase
    end
  end

endmodule
